mult_rr_scheduler: RTL and testbench

- Shares one combinational NxN array multiplier (ArrayMultiplier_NxN) among R requesters.
- Arbitration is round-robin, with a valid/ready handshake on each requester port.
- Products are registered and returned on a single result port, tagged with the requester index.
- Sits between independent DSP blocks (filters, MAC stages) so they can share one multiplier and save area.

---
 rtl/mult_rr_pkg.sv | 14 +
 rtl/ArrayMultiplier_NxN.sv | 23 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/mult_rr_scheduler.sv | 153 +++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_rr_pkg.sv
// Shared constants and helpers for the round-robin multiplier scheduler.
package mult_rr_pkg;

  localparam int unsigned MAX_REQ = 4;

  function automatic int unsigned id_width(input int unsigned r);
    return (r > 2) ? 32'd2 : 32'd1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned r);
    return (idx + 32'd1 >= r) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/ArrayMultiplier_NxN.sv
// Combinational unsigned NxN array multiplier producing a full 2N-bit product.
module ArrayMultiplier_NxN #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] prod_o
);

  logic [2*N-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (b_i[i]) begin
        acc = acc + ({{N{1'b0}}, a_i} << i);
      end
    end
  end

  assign prod_o = acc;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from ptr upward; ptr moves past the
// winner only when the grant is actually taken (advance).
module rr_arbiter
  import mult_rr_pkg::*;
#(
  parameter int unsigned  R    = 2,
  localparam int unsigned ID_W = id_width(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req,
  input  logic            advance,
  output logic [R-1:0]    grant,
  output logic [ID_W-1:0] gidx
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = (32'(ptr_q) + k) % R;
      if (!found && |(req & (R'(1) << idx))) begin
        grant = R'(1) << idx;
        gidx  = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign ptr_d = advance ? ID_W'(rr_next(32'(gidx), R)) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one array multiplier among R requesters with round-robin arbitration.
// Define MULT_RR_IN_REG_EN to add an operand register stage (latency 2).
module mult_rr_scheduler
  import mult_rr_pkg::*;
#(
  parameter int unsigned  N    = 8,
  parameter int unsigned  R    = 2,
  localparam int unsigned ID_W = id_width(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req_valid,
  output logic [R-1:0]    req_ready,
  input  logic [R*N-1:0]  req_a,
  input  logic [R*N-1:0]  req_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [2*N-1:0]  res_prod,
  output logic [ID_W-1:0] res_id,
  output logic            busy
);

  if (R < 2 || R > MAX_REQ) begin : g_bad_r
    $error("mult_rr_scheduler: R out of range");
  end

  logic [R-1:0]    grant;
  logic [ID_W-1:0] gidx;
  logic            can_accept, in_accept, xfer;
  logic [N-1:0]    op_a, op_b, mul_a, mul_b;
  logic [2*N-1:0]  prod;
  logic            load;
  logic [ID_W-1:0] load_id;

  logic            res_valid_q, res_valid_d;
  logic [2*N-1:0]  res_prod_q, res_prod_d;
  logic [ID_W-1:0] res_id_q, res_id_d;

  assign can_accept = !res_valid_q || res_ready;
  // Gate with rst_n so nothing is accepted while reset is held.
  assign req_ready  = grant & {R{in_accept & rst_n}};
  assign xfer       = |req_ready;

  rr_arbiter #(
    .R(R)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .advance(xfer),
    .grant  (grant),
    .gidx   (gidx)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < R; i++) begin
      if (grant[i]) begin
        op_a = req_a[i*N +: N];
        op_b = req_b[i*N +: N];
      end
    end
  end

`ifdef MULT_RR_IN_REG_EN
  logic            s1_v_q, s1_v_d;
  logic [N-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  assign in_accept = !s1_v_q || can_accept;
  assign mul_a     = s1_a_q;
  assign mul_b     = s1_b_q;
  assign load      = s1_v_q && can_accept;
  assign load_id   = s1_id_q;
  assign busy      = res_valid_q | s1_v_q;

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_id_d = s1_id_q;
    if (xfer) begin
      s1_v_d  = 1'b1;
      s1_a_d  = op_a;
      s1_b_d  = op_b;
      s1_id_d = gidx;
    end else if (can_accept) begin
      s1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_id_q <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_id_q <= s1_id_d;
    end
  end
`else
  assign in_accept = can_accept;
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign load      = xfer;
  assign load_id   = gidx;
  assign busy      = res_valid_q;
`endif

  ArrayMultiplier_NxN #(
    .N(N)
  ) u_mul (
    .a_i   (mul_a),
    .b_i   (mul_b),
    .prod_o(prod)
  );

  // A load in the same cycle as a leave overwrites the result without a bubble.
  always_comb begin
    res_valid_d = res_valid_q;
    res_prod_d  = res_prod_q;
    res_id_d    = res_id_q;
    if (load) begin
      res_valid_d = 1'b1;
      res_prod_d  = prod;
      res_id_d    = load_id;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_prod_q  <= '0;
      res_id_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_prod_q  <= res_prod_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_prod  = res_prod_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler (R=4): directed cases plus random traffic
// against a transaction-level reference model and per-requester scoreboard.
module tb_mult_rr_scheduler;

  localparam int unsigned N    = 8;
  localparam int unsigned R    = 4;
  localparam int unsigned ID_W = 2;
`ifdef MULT_RR_IN_REG_EN
  localparam bit TwoStage = 1'b1;
  localparam int Lat      = 2;
`else
  localparam bit TwoStage = 1'b0;
  localparam int Lat      = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [R-1:0]    req_valid;
  logic [R-1:0]    req_ready;
  logic [R*N-1:0]  req_a, req_b;
  logic            res_valid;
  logic            res_ready;
  logic [2*N-1:0]  res_prod;
  logic [ID_W-1:0] res_id;
  logic            busy;

  always #5 clk = ~clk;

  mult_rr_scheduler #(
    .N(N),
    .R(R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_prod (res_prod),
    .res_id   (res_id),
    .busy     (busy)
  );

  typedef struct {
    int id;
    int prod;
    int cyc;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: pointer, optional operand stage, output register.
  int m_ptr;
  bit m_s1_v;
  int m_s1_p, m_s1_id;
  bit m_res_v;
  int m_res_p, m_res_id;

  int           sb_q [R][$];
  ent_t         log_q[$];
  logic [R-1:0] last_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [R*N-1:0] pack4(input int x0, input int x1, input int x2,
                                           input int x3);
    return {N'(x3), N'(x2), N'(x1), N'(x0)};
  endfunction

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      default: return N'($urandom);
    endcase
  endfunction

  function automatic void model_clear();
    m_ptr    = 0;
    m_s1_v   = 0;
    m_s1_p   = 0;
    m_s1_id  = 0;
    m_res_v  = 0;
    m_res_p  = 0;
    m_res_id = 0;
    for (int i = 0; i < R; i++) sb_q[i].delete();
    log_q.delete();
  endfunction

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic cycle(input logic [R-1:0] v, input logic [R*N-1:0] a, input logic [R*N-1:0] b,
                       input logic rr, output int gi);
    int           g, p;
    bit           out_acc, in_acc;
    logic [R-1:0] exp_ready;
    logic [N-1:0] xa, xb;
    ent_t         e;
    @(negedge clk);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = rr;
    #1;
    g = -1;
    for (int k = 0; k < R; k++) begin
      int idx;
      idx = (m_ptr + k) % R;
      if (g < 0 && v[idx]) g = idx;
    end
    out_acc   = !m_res_v || rr;
    in_acc    = TwoStage ? (!m_s1_v || out_acc) : out_acc;
    exp_ready = '0;
    if (g >= 0 && in_acc) exp_ready[g] = 1'b1;
    last_ready = req_ready;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("res_valid", 32'(res_valid), 32'(m_res_v));
    check_eq("res_prod", 32'(res_prod), m_res_p);
    check_eq("res_id", 32'(res_id), m_res_id);
    check_eq("busy", 32'(busy), 32'(m_res_v || m_s1_v));
    if (res_valid === 1'b1 && rr) begin
      check_eq("sb_pending", 32'(sb_q[res_id].size() > 0), 1);
      if (sb_q[res_id].size() > 0) check_eq("sb_prod", 32'(res_prod), sb_q[res_id].pop_front());
      e.id   = int'(res_id);
      e.prod = int'(res_prod);
      e.cyc  = cyc;
      log_q.push_back(e);
    end
    gi = -1;
    p  = 0;
    if (exp_ready != '0) begin
      xa = a[g*N +: N];
      xb = b[g*N +: N];
      p  = int'(xa) * int'(xb);
      sb_q[g].push_back(p);
      gi = g;
    end
    if (TwoStage) begin
      if (m_s1_v && out_acc) begin
        m_res_v  = 1;
        m_res_p  = m_s1_p;
        m_res_id = m_s1_id;
      end else if (rr) begin
        m_res_v = 0;
      end
      if (gi >= 0) begin
        m_s1_v  = 1;
        m_s1_p  = p;
        m_s1_id = gi;
      end else if (out_acc) begin
        m_s1_v = 0;
      end
    end else begin
      if (gi >= 0) begin
        m_res_v  = 1;
        m_res_p  = p;
        m_res_id = gi;
      end else if (rr) begin
        m_res_v = 0;
      end
    end
    if (gi >= 0) m_ptr = (gi + 1) % R;
    cyc++;
  endtask

  task automatic drain(input int n);
    int g;
    repeat (n) cycle('0, '0, '0, 1'b1, g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b0;
    #1;
    check_eq("rst_res_valid", 32'(res_valid), 0);
    check_eq("rst_res_prod", 32'(res_prod), 0);
    check_eq("rst_res_id", 32'(res_id), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    model_clear();
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    int           g, c0, nx;
    logic [R-1:0] cv;
    logic [R*N-1:0] ca, cb;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    model_clear();

    // Single request and latency.
    do_reset();
    c0 = cyc;
    cycle(4'b0001, pack4(200, 0, 0, 0), pack4(150, 0, 0, 0), 1'b1, g);
    check_eq("single_ready", 32'(last_ready), 32'h1);
    drain(3);
    check_eq("single_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check_eq("single_prod", log_q[0].prod, 30000);
      check_eq("single_id", log_q[0].id, 0);
      check_eq("single_lat", log_q[0].cyc - c0, Lat);
    end

    // Contention fairness between requesters 0 and 1.
    do_reset();
    repeat (8) cycle(4'b0011, pack4(3, 5, 0, 0), pack4(4, 6, 0, 0), 1'b1, g);
    drain(3);
    check_eq("fair_count", log_q.size(), 8);
    for (int i = 0; i < log_q.size(); i++) begin
      check_eq("fair_id", log_q[i].id, i % 2);
      check_eq("fair_prod", log_q[i].prod, (i % 2 == 1) ? 30 : 12);
    end

    // Backpressure for 3 cycles, then release.
    do_reset();
    cycle(4'b0011, pack4(3, 5, 0, 0), pack4(4, 6, 0, 0), 1'b1, g);
    repeat (3) cycle(4'b0011, pack4(3, 5, 0, 0), pack4(4, 6, 0, 0), 1'b0, g);
    check_eq("bp_pending", 32'(res_valid), 1);
    repeat (2) cycle(4'b0011, pack4(3, 5, 0, 0), pack4(4, 6, 0, 0), 1'b1, g);
    drain(3);
    if (log_q.size() >= 2) begin
      check_eq("bp_first_id", log_q[0].id, 0);
      check_eq("bp_second_id", log_q[1].id, 1);
    end else begin
      check_eq("bp_count", log_q.size(), 2);
    end

    // Boundary operands, back to back.
    do_reset();
    cycle(4'b0001, pack4(255, 0, 0, 0), pack4(255, 0, 0, 0), 1'b1, g);
    cycle(4'b0010, pack4(0, 0, 0, 0), pack4(0, 255, 0, 0), 1'b1, g);
    drain(3);
    check_eq("bnd_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check_eq("bnd_max", log_q[0].prod, 65025);
      check_eq("bnd_zero", log_q[1].prod, 0);
      check_eq("bnd_zero_id", log_q[1].id, 1);
      check_eq("bnd_no_gap", log_q[1].cyc - log_q[0].cyc, 1);
    end

    // Reset while a result is pending.
    do_reset();
    repeat (Lat + 1) cycle(4'b0100, pack4(0, 0, 7, 0), pack4(0, 0, 9, 0), 1'b0, g);
    check_eq("mid_valid_before", 32'(res_valid), 1);
    do_reset();
    cycle(4'b1111, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, g);
    check_eq("mid_first_grant", 32'(last_ready), 32'h1);
    drain(3);

    // Random traffic with random backpressure and legal valid drops.
    do_reset();
    nx = 0;
    cv = '0;
    ca = '0;
    cb = '0;
    for (int c = 0; c < 20000 && nx < 1000; c++) begin
      for (int i = 0; i < R; i++) begin
        if (cv[i]) begin
          if ($urandom_range(15) == 0) cv[i] = 1'b0;
        end else begin
          cv[i]         = ($urandom_range(2) != 0);
          ca[i*N +: N]  = rnd_op();
          cb[i*N +: N]  = rnd_op();
        end
      end
      cycle(cv, ca, cb, ($urandom_range(3) != 0), g);
      if (g >= 0) begin
        nx++;
        cv[g] = 1'b0;
      end
    end
    drain(4);
    check_eq("rnd_transfers", 32'(nx >= 1000), 1);
    for (int i = 0; i < R; i++) check_eq("rnd_sb_empty", sb_q[i].size(), 0);
    check_eq("rnd_idle_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
